// File: rtl/rv32i_alu_exec_core.sv
// Single-cycle RV32I integer execute core: decode, 32x32 register file, ALU, write-back.
// Optional macro ALU_LUI_EN makes LUI (opcode 0110111) a legal instruction.
`timescale 1ns/1ps
module rv32i_alu_exec_core #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32
) (
   input  logic            clock_i,
   input  logic            resetb_i,
   input  logic [XLEN-1:0] instruction_i,
   input  logic            write_ena_i,
   input  logic [4:0]      dbg_addr_i,
   output logic [XLEN-1:0] dbg_data_o,
   output logic [XLEN-1:0] result_o,
   output logic            illegal_o
);

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] F7_BASE    = 7'b0000000;
   localparam logic [6:0] F7_ALT     = 7'b0100000;

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
      ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
   } alu_op_e;

   logic [XLEN-1:0] regs_q [NREGS];
   logic [XLEN-1:0] regs_d [NREGS];

   logic [6:0]      opcode;
   logic [4:0]      rd;
   logic [2:0]      funct3;
   logic [4:0]      rs1;
   logic [4:0]      rs2;
   logic [6:0]      funct7;
   logic [XLEN-1:0] imm_i;
   logic [XLEN-1:0] rs1_val;
   logic [XLEN-1:0] rs2_val;

   alu_op_e         alu_op;
   logic [XLEN-1:0] op_b;
   logic [4:0]      shamt;
   logic            illegal;
   logic [XLEN-1:0] alu_out;
   logic            wr_en;

   assign opcode = instruction_i[6:0];
   assign rd     = instruction_i[11:7];
   assign funct3 = instruction_i[14:12];
   assign rs1    = instruction_i[19:15];
   assign rs2    = instruction_i[24:20];
   assign funct7 = instruction_i[31:25];
   assign imm_i  = {{(XLEN-12){instruction_i[31]}}, instruction_i[31:20]};

   // x0 is hardwired to zero on every read port
   assign rs1_val    = (rs1 == 5'd0) ? '0 : regs_q[rs1];
   assign rs2_val    = (rs2 == 5'd0) ? '0 : regs_q[rs2];
   assign dbg_data_o = (dbg_addr_i == 5'd0) ? '0 : regs_q[dbg_addr_i];

   always_comb begin
      alu_op  = ALU_ADD;
      op_b    = '0;
      shamt   = 5'd0;
      illegal = 1'b1;
      unique case (opcode)
         OPC_OP: begin
            op_b  = rs2_val;
            shamt = rs2_val[4:0];
            unique case (funct3)
               3'b000: begin
                  alu_op  = (funct7 == F7_ALT) ? ALU_SUB : ALU_ADD;
                  illegal = !((funct7 == F7_BASE) || (funct7 == F7_ALT));
               end
               3'b101: begin
                  alu_op  = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                  illegal = !((funct7 == F7_BASE) || (funct7 == F7_ALT));
               end
               default: begin
                  illegal = (funct7 != F7_BASE);
                  unique case (funct3)
                     3'b001:  alu_op = ALU_SLL;
                     3'b010:  alu_op = ALU_SLT;
                     3'b011:  alu_op = ALU_SLTU;
                     3'b100:  alu_op = ALU_XOR;
                     3'b110:  alu_op = ALU_OR;
                     default: alu_op = ALU_AND;
                  endcase
               end
            endcase
         end
         OPC_OP_IMM: begin
            op_b    = imm_i;
            shamt   = instruction_i[24:20];
            illegal = 1'b0;
            unique case (funct3)
               3'b000: alu_op = ALU_ADD;
               3'b001: begin
                  alu_op  = ALU_SLL;
                  illegal = (funct7 != F7_BASE);
               end
               3'b010: alu_op = ALU_SLT;
               3'b011: alu_op = ALU_SLTU;
               3'b100: alu_op = ALU_XOR;
               3'b101: begin
                  alu_op  = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                  illegal = !((funct7 == F7_BASE) || (funct7 == F7_ALT));
               end
               3'b110:  alu_op = ALU_OR;
               default: alu_op = ALU_AND;
            endcase
         end
`ifdef ALU_LUI_EN
         OPC_LUI: begin
            alu_op  = ALU_PASS_B;
            op_b    = {instruction_i[31:12], 12'h000};
            illegal = 1'b0;
         end
`else
         OPC_LUI: begin
            illegal = 1'b1;
         end
`endif
         default: begin
            illegal = 1'b1;
         end
      endcase
   end

   always_comb begin
      alu_out = '0;
      unique case (alu_op)
         ALU_ADD:    alu_out = rs1_val + op_b;
         ALU_SUB:    alu_out = rs1_val - op_b;
         ALU_SLL:    alu_out = rs1_val << shamt;
         ALU_SLT:    alu_out = {{(XLEN-1){1'b0}}, ($signed(rs1_val) < $signed(op_b))};
         ALU_SLTU:   alu_out = {{(XLEN-1){1'b0}}, (rs1_val < op_b)};
         ALU_XOR:    alu_out = rs1_val ^ op_b;
         ALU_SRL:    alu_out = rs1_val >> shamt;
         ALU_SRA:    alu_out = $unsigned($signed(rs1_val) >>> shamt);
         ALU_OR:     alu_out = rs1_val | op_b;
         ALU_AND:    alu_out = rs1_val & op_b;
         ALU_PASS_B: alu_out = op_b;
         default:    alu_out = '0;
      endcase
   end

   assign illegal_o = illegal;
   assign result_o  = illegal ? '0 : alu_out;

   // An X/Z write enable falls into the no-write branch
   always_comb begin
      wr_en = 1'b0;
      if (write_ena_i == 1'b1) begin
         wr_en = !illegal && (rd != 5'd0);
      end
   end

   always_comb begin
      regs_d = regs_q;
      if (wr_en) begin
         regs_d[rd] = result_o;
      end
   end

   always_ff @(posedge clock_i or negedge resetb_i) begin
      if (!resetb_i) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         regs_q <= regs_d;
      end
   end

endmodule

// File: tb/tb_rv32i_alu_exec_core.sv
// Scoreboard bench for rv32i_alu_exec_core: directed sequences plus randomized
// instructions checked against a mnemonic-level reference model.
`timescale 1ns/1ps
module tb_rv32i_alu_exec_core;

   logic        clock_i;
   logic        resetb_i;
   logic [31:0] instruction_i;
   logic        write_ena_i;
   logic [4:0]  dbg_addr_i;
   logic [31:0] dbg_data_o;
   logic [31:0] result_o;
   logic        illegal_o;

   rv32i_alu_exec_core dut (
      .clock_i       (clock_i),
      .resetb_i      (resetb_i),
      .instruction_i (instruction_i),
      .write_ena_i   (write_ena_i),
      .dbg_addr_i    (dbg_addr_i),
      .dbg_data_o    (dbg_data_o),
      .result_o      (result_o),
      .illegal_o     (illegal_o)
   );

   typedef struct {
      logic [31:0] result;
      logic        illegal;
      logic [31:0] dbg;
   } exp_t;

   exp_t        exp_q [$];
   logic [31:0] model_regs [32];
   int          n_pass  = 0;
   int          n_total = 0;

   initial begin
      clock_i = 1'b0;
      forever #5 clock_i = ~clock_i;
   end

   function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                         logic [2:0] f3, logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, 7'h33};
   endfunction

   function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] rs1,
                                         logic [2:0] f3, logic [4:0] rd);
      return {imm, rs1, f3, rd, 7'h13};
   endfunction

   // Reference semantics written per mnemonic; a and b are the rs1/rs2 register values
   function automatic void ref_exec(input logic [31:0] ins, input logic [31:0] a,
                                    input logic [31:0] b, output logic [31:0] res,
                                    output logic ill);
      logic [31:0] imm;
      logic [31:0] opb;
      int          sh;
      imm = {{20{ins[31]}}, ins[31:20]};
      res = 32'd0;
      ill = 1'b0;
      if (ins[6:0] == 7'h33 || ins[6:0] == 7'h13) begin
         opb = (ins[6:0] == 7'h33) ? b : imm;
         sh  = int'(opb[4:0]);
         case (ins[14:12])
            3'd0: begin
               if (ins[6:0] == 7'h13 || ins[31:25] == 7'h00) res = a + opb;
               else if (ins[31:25] == 7'h20) res = a - opb;
               else ill = 1'b1;
            end
            3'd1: if (ins[31:25] == 7'h00) res = a << sh; else ill = 1'b1;
            3'd5: begin
               if (ins[31:25] == 7'h00) res = a >> sh;
               else if (ins[31:25] == 7'h20) res = 32'($signed(a) >>> sh);
               else ill = 1'b1;
            end
            default: begin
               if (ins[6:0] == 7'h33 && ins[31:25] != 7'h00) ill = 1'b1;
               case (ins[14:12])
                  3'd2:    res = ($signed(a) < $signed(opb)) ? 32'd1 : 32'd0;
                  3'd3:    res = (a < opb) ? 32'd1 : 32'd0;
                  3'd4:    res = a ^ opb;
                  3'd6:    res = a | opb;
                  default: res = a & opb;
               endcase
            end
         endcase
      end
`ifdef ALU_LUI_EN
      else if (ins[6:0] == 7'h37) begin
         res = {ins[31:12], 12'h000};
      end
`endif
      else begin
         ill = 1'b1;
      end
      if (ill) res = 32'd0;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
      n_total++;
      if (got === want) n_pass++;
      else $display("[TB] FAIL %s: got %h expected %h at %0t", name, got, want, $time);
   endtask

   // Drive one instruction, queue its expected response, then advance the model across the edge
   task automatic applyStimulus(input logic [31:0] ins, input logic we, input logic [4:0] dbg);
      exp_t        e;
      logic [31:0] res;
      logic        ill;
      @(negedge clock_i);
      #1;
      instruction_i = ins;
      write_ena_i   = we;
      dbg_addr_i    = dbg;
      ref_exec(ins, model_regs[ins[19:15]], model_regs[ins[24:20]], res, ill);
      e.result  = res;
      e.illegal = ill;
      e.dbg     = model_regs[dbg];
      exp_q.push_back(e);
      if (resetb_i === 1'b1 && we === 1'b1 && !ill && ins[11:7] != 5'd0)
         model_regs[ins[11:7]] = res;
   endtask

   // Read a register through the debug port against a fixed expected value
   task automatic expectReg(input logic [4:0] idx, input logic [31:0] val);
      exp_t e;
      @(negedge clock_i);
      #1;
      instruction_i = 32'h0000007F;
      write_ena_i   = 1'b1;
      dbg_addr_i    = idx;
      e.result  = 32'd0;
      e.illegal = 1'b1;
      e.dbg     = val;
      exp_q.push_back(e);
   endtask

   task automatic resetMidOp();
      exp_t        e;
      logic [31:0] res;
      logic        ill;
      @(negedge clock_i);
      #1;
      instruction_i = 32'h00108093;
      write_ena_i   = 1'b1;
      dbg_addr_i    = 5'd1;
      ref_exec(instruction_i, model_regs[1], model_regs[1], res, ill);
      e.result  = res;
      e.illegal = ill;
      e.dbg     = model_regs[1];
      exp_q.push_back(e);
      #2.5;
      resetb_i = 1'b0;
      for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
      #0.5;
      checkOutput("dbg_x1_immediately_in_reset", dbg_data_o, 32'd0);
      for (int i = 0; i < 3; i++) applyStimulus(32'h00108093, 1'b1, 5'd1);
      @(negedge clock_i);
      #1;
      write_ena_i = 1'b0;
      #1;
      resetb_i = 1'b1;
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clock_i);
         #3;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput("result_o", result_o, e.result);
            checkOutput("illegal_o", {31'd0, illegal_o}, {31'd0, e.illegal});
            checkOutput($sformatf("dbg_x%0d", dbg_addr_i), dbg_data_o, e.dbg);
         end
      end
   end

   initial begin
      logic [31:0] ins;
      logic [6:0]  f7;
      logic [11:0] imm;
      logic [2:0]  f3;
      int          k;
      int          wait_cycles;
      resetb_i      = 1'b1;
      instruction_i = 32'h0000007F;
      write_ena_i   = 1'b0;
      dbg_addr_i    = 5'd0;
      for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
      #2;
      resetb_i = 1'b0;
      #50;
      resetb_i = 1'b1;

      for (int i = 0; i < 32; i++) expectReg(5'(i), 32'd0);

      applyStimulus(32'h00108093, 1'b1, 5'd1);
      applyStimulus(32'h00108133, 1'b1, 5'd1);
      applyStimulus(32'h001101b3, 1'b1, 5'd2);
      expectReg(5'd1, 32'd1);
      expectReg(5'd2, 32'd2);
      expectReg(5'd3, 32'd3);

      for (int i = 0; i < 3; i++) applyStimulus(32'h00108093, 1'b0, 5'd1);
      expectReg(5'd1, 32'd1);

      applyStimulus(enc_i(12'd5, 5'd0, 3'd0, 5'd0), 1'b1, 5'd0);
      expectReg(5'd0, 32'd0);
      applyStimulus(enc_i(12'hFF0, 5'd0, 3'd0, 5'd1), 1'b1, 5'd1);
      applyStimulus(enc_i(12'h402, 5'd1, 3'd5, 5'd4), 1'b1, 5'd1);
      applyStimulus(enc_r(7'h20, 5'd1, 5'd0, 3'd0, 5'd5), 1'b1, 5'd4);
      applyStimulus(enc_r(7'h00, 5'd1, 5'd0, 3'd3, 5'd6), 1'b1, 5'd5);
      applyStimulus(enc_r(7'h00, 5'd1, 5'd0, 3'd2, 5'd7), 1'b1, 5'd6);
      expectReg(5'd1, 32'hFFFFFFF0);
      expectReg(5'd4, 32'hFFFFFFFC);
      expectReg(5'd5, 32'h00000010);
      expectReg(5'd6, 32'd1);
      expectReg(5'd7, 32'd0);

      applyStimulus(32'h0000007F, 1'b1, 5'd1);
      applyStimulus(enc_r(7'h01, 5'd1, 5'd1, 3'd0, 5'd8), 1'b1, 5'd8);
      expectReg(5'd8, 32'd0);
      applyStimulus({20'h12345, 5'd9, 7'h37}, 1'b1, 5'd9);
`ifdef ALU_LUI_EN
      expectReg(5'd9, 32'h12345000);
`else
      expectReg(5'd9, 32'd0);
`endif

      for (int n = 0; n < 400; n++) begin
         k  = $urandom_range(0, 9);
         f3 = 3'($urandom_range(0, 7));
         case ($urandom_range(0, 7))
            5, 6:    f7 = 7'h20;
            7:       f7 = 7'($urandom);
            default: f7 = 7'h00;
         endcase
         if (k <= 3) begin
            ins = enc_r(f7, 5'($urandom), 5'($urandom), f3, 5'($urandom));
         end else if (k <= 7) begin
            imm = 12'($urandom);
            if (f3 == 3'd1 || f3 == 3'd5) imm[11:5] = f7;
            ins = enc_i(imm, 5'($urandom), f3, 5'($urandom));
         end else if (k == 8) begin
            ins = {20'($urandom), 5'($urandom), 7'h37};
         end else begin
            ins = $urandom;
         end
         applyStimulus(ins, ($urandom_range(0, 4) != 0), 5'($urandom));
      end

      applyStimulus(enc_i(12'h055, 5'd0, 3'd0, 5'd1), 1'b1, 5'd1);
      resetMidOp();
      expectReg(5'd1, 32'd0);
      for (int i = 0; i < 32; i++) applyStimulus(32'h0000007F, 1'b1, 5'(i));

      wait_cycles = 0;
      while (exp_q.size() > 0 && wait_cycles < 20) begin
         @(negedge clock_i);
         wait_cycles++;
      end
      if (exp_q.size() > 0) begin
         n_total++;
         $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
      end
      #10;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
